imem_boot_loader: RTL and testbench
===================================

Name: imem_boot_loader

Overview:
- Hardware counterpart of the simulation program-load and stop-detection flow for the pipelined xgriscv core.
- Receives a program image as a byte stream and writes it word by word into instruction memory, holding the core in reset meanwhile.
- Releases the core, counts run cycles, and declares halt when the writeback PC reaches the last loaded instruction.
- Sits between an external byte source (UART/debug bridge) and xgriscv_pipeline's U_imem write port and reset input.

Parameters:
- ADDR_SIZE, 32: width of imem byte address and pcW (matches `ADDR_SIZE).
- DEPTH_WORDS, 1024: imem capacity in 32-bit words; maximum legal image length.
- PIPE_DEPTH, 5: run cycles before a pcW match is honoured; masks the core's pipeline fill.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rstn  in  1  reset; synchronous, active-high (asserted = 1); port name rstn as in the codebase.
- rx_valid  in  1  byte-stream source has a byte.
- rx_data  in  8  stream byte.
- rx_ready  out  1  loader accepts a byte this cycle; transfer occurs when rx_valid && rx_ready.
- imem_we  out  1  one-cycle imem write strobe.
- imem_addr  out  ADDR_SIZE  byte address of the write, word aligned (4*index).
- imem_wdata  out  32  instruction word.
- cpu_rst  out  1  reset to the core, active-high.
- pcW  in  ADDR_SIZE  core writeback-stage PC.
- busy  out  1  state is HDR0, HDR1 or LOAD.
- halted  out  1  program reached its last instruction.
- err  out  1  illegal header length.
- cycle_count  out  32  cycles spent in RUN.

Behaviour:
- Reset (rstn = 1 at an edge) forces state HDR0, regardless of current state (including mid-LOAD and mid-RUN).
- Output values in reset: rx_ready 0 while rstn = 1, imem_we 0, imem_addr 0, imem_wdata 0, cpu_rst 1, busy 1, halted 0, err 0, cycle_count 0.
- States: HDR0, HDR1, LOAD, RUN, HALT, ERR.
- rx_ready is combinational from state: 1 in HDR0, HDR1 and LOAD; 0 in all others.
- HDR0: the accepted byte is N[7:0]; go to HDR1.
- HDR1: the accepted byte is N[15:8].
  - If N == 0 or N > DEPTH_WORDS: go to ERR.
  - Otherwise: go to LOAD, word index 0, byte lane 0, end_pc = 4*(N-1) truncated to ADDR_SIZE.
- LOAD:
  - Bytes are assembled little-endian: lane 0 goes to bits [7:0], lane 3 to bits [31:24].
  - On acceptance of lane 3, in the next cycle: imem_we = 1, imem_addr = 4*index, imem_wdata = assembled word. Then index increments.
  - Acceptance continues during the write cycle, so there is no bubble and the source may stream 1 byte per cycle.
  - Gaps (rx_valid = 0) stall assembly indefinitely; partial-word state is held.
  - On the write of word N-1, go to RUN. cpu_rst falls in the first RUN cycle, the cycle after that write.
- RUN:
  - cycle_count increments every cycle and saturates at 0xFFFFFFFF.
  - Halt condition: pcW == end_pc && cycle_count >= PIPE_DEPTH-1. When met, go to HALT at the next edge.
  - The matching cycle is counted.
- HALT: halted = 1, cpu_rst = 1 (core frozen), cycle_count holds. Exit only by reset.
- ERR: err = 1, cpu_rst = 1, no imem writes. Exit only by reset.
- imem_we is never asserted outside the cycle after a lane-3 acceptance in LOAD.
- imem_addr and imem_wdata hold their last values when imem_we = 0.

Decomposition:
- Shared package imem_boot_pkg:
  - state enum encoding for the six states;
  - HDR_BYTES = 2 and BYTES_PER_WORD = 4;
  - ADDR_SIZE reuse from xgriscv_defines.
- One sub-module, byte_word_packer:
  - lane counter plus 32-bit shift/assemble register;
  - emits a word_valid pulse and the word;
  - cleared by a load-start signal.

Test Plan:
- Reset then header 0x03,0x00 and 12 bytes streamed back-to-back -> exactly 3 imem_we pulses:
  - addr 0x0 with data taken from bytes 0..3 little-endian;
  - addr 0x4;
  - addr 0x8;
  - cpu_rst falls the cycle after the 0x8 write.
- Same image with rx_valid toggled every other cycle -> identical write sequence, cpu_rst falls only after the third write.
- Header 0x00,0x00 -> err = 1, rx_ready = 0, no imem_we, cpu_rst = 1; header N = DEPTH_WORDS+1 -> same result.
- After loading N = 0x1F words (end_pc = 0x78), drive pcW sequence 0x0…0x78 -> halted = 1 the cycle after pcW = 0x78, cpu_rst = 1, cycle_count frozen at that value.
- N = 1 (end_pc = 0) with pcW = 0 from the start -> no halt before cycle_count reaches 4; halted asserts on the following edge.
- Assert rstn mid-LOAD after 6 payload bytes, then reload N = 2 -> writes start at addr 0x0, no stale partial word, err/halted stay 0.

Source files
------------

// File: rtl/imem_boot_pkg.sv
// Shared constants, state encoding and header helper for the instruction-memory boot loader.
package imem_boot_pkg;

    localparam int unsigned XG_ADDR_SIZE   = 32;
    localparam int unsigned HDR_BYTES      = 2;
    localparam int unsigned BYTES_PER_WORD = 4;
    localparam int unsigned HDR_BITS       = 8 * HDR_BYTES;
    localparam int unsigned LANE_W         = $clog2(BYTES_PER_WORD);

    localparam logic [2:0] StHdr0 = 3'd0;
    localparam logic [2:0] StHdr1 = 3'd1;
    localparam logic [2:0] StLoad = 3'd2;
    localparam logic [2:0] StRun  = 3'd3;
    localparam logic [2:0] StHalt = 3'd4;
    localparam logic [2:0] StErr  = 3'd5;

    // A legal image holds at least one word and fits in instruction memory.
    function automatic logic hdr_len_ok(input logic [HDR_BITS-1:0] n, input int unsigned depth);
        return (n != '0) && (32'(n) <= depth);
    endfunction

endpackage

// File: rtl/imem_boot_loader_if.sv
// Byte-stream input and instruction-memory write port of the boot loader.
interface imem_boot_loader_if
    import imem_boot_pkg::*;
#(
    parameter int unsigned ADDR_SIZE = XG_ADDR_SIZE
) ();

    logic                 rx_valid;
    logic [7:0]           rx_data;
    logic                 rx_ready;
    logic                 imem_we;
    logic [ADDR_SIZE-1:0] imem_addr;
    logic [31:0]          imem_wdata;

    modport master (
        output rx_valid,
        output rx_data,
        input  rx_ready,
        input  imem_we,
        input  imem_addr,
        input  imem_wdata
    );

    modport slave (
        input  rx_valid,
        input  rx_data,
        output rx_ready,
        output imem_we,
        output imem_addr,
        output imem_wdata
    );

endinterface

// File: rtl/imem_boot_loader_byte_word_packer.sv
// Assembles little-endian bytes into 32-bit words and emits a one-cycle word_valid pulse
// in the cycle after the last lane is accepted.
module byte_word_packer
    import imem_boot_pkg::*;
(
    input  logic        clk,
    input  logic        rstn,
    input  logic        clear,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        lane_last,
    output logic        word_valid,
    output logic [31:0] word
);

    localparam int unsigned AsmW = 8 * (BYTES_PER_WORD - 1);
    localparam logic [LANE_W-1:0] LastLane = LANE_W'(BYTES_PER_WORD - 1);

    logic [LANE_W-1:0] lane_q, lane_d;
    logic [AsmW-1:0]   asm_q, asm_d;
    logic [31:0]       word_q, word_d;
    logic              word_valid_q, word_valid_d;

    assign lane_last  = (lane_q == LastLane);
    assign word_valid = word_valid_q;
    assign word       = word_q;

    always_comb begin
        lane_d       = lane_q;
        asm_d        = asm_q;
        word_d       = word_q;
        word_valid_d = 1'b0;
        if (clear) begin
            lane_d = '0;
            asm_d  = '0;
        end else if (byte_valid) begin
            if (lane_last) begin
                word_d       = {byte_data, asm_q};
                word_valid_d = 1'b1;
                lane_d       = '0;
                asm_d        = '0;
            end else begin
                for (int i = 0; i < int'(BYTES_PER_WORD) - 1; i++) begin
                    if (lane_q == LANE_W'(i)) begin
                        asm_d[8*i +: 8] = byte_data;
                    end
                end
                lane_d = lane_q + LANE_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rstn) begin
            lane_q       <= '0;
            asm_q        <= '0;
            word_q       <= '0;
            word_valid_q <= 1'b0;
        end else begin
            lane_q       <= lane_d;
            asm_q        <= asm_d;
            word_q       <= word_d;
            word_valid_q <= word_valid_d;
        end
    end

endmodule

// File: rtl/imem_boot_loader.sv
// Streams a length-prefixed program image into instruction memory, then runs the core and
// flags halt once the writeback PC reaches the last loaded instruction.
module imem_boot_loader
    import imem_boot_pkg::*;
#(
    parameter int unsigned ADDR_SIZE   = XG_ADDR_SIZE,
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned PIPE_DEPTH  = 5
) (
    input  logic                 clk,
    input  logic                 rstn,
    imem_boot_loader_if.slave    bus,
    input  logic [ADDR_SIZE-1:0] pcW,
    output logic                 cpu_rst,
    output logic                 busy,
    output logic                 halted,
    output logic                 err,
    output logic [31:0]          cycle_count
);

    logic [2:0]           state_q, state_d;
    logic [7:0]           n_lo_q, n_lo_d;
    logic [HDR_BITS-1:0]  n_q, n_d;
    logic [HDR_BITS-1:0]  index_q, index_d;
    logic [ADDR_SIZE-1:0] end_pc_q, end_pc_d;
    logic [ADDR_SIZE-1:0] addr_q, addr_d;
    logic [31:0]          count_q, count_d;

    logic                 stream_state;
    logic                 accept;
    logic                 load_start;
    logic [HDR_BITS-1:0]  n_hdr;
    logic                 pk_lane_last;
    logic                 pk_word_valid;
    logic [31:0]          pk_word;

    assign stream_state = (state_q == StHdr0) || (state_q == StHdr1) || (state_q == StLoad);
    assign bus.rx_ready = stream_state && !rstn;
    assign accept       = bus.rx_valid && bus.rx_ready;
    assign n_hdr        = {bus.rx_data, n_lo_q};
    assign load_start   = accept && (state_q == StHdr1) && hdr_len_ok(n_hdr, DEPTH_WORDS);

    byte_word_packer u_packer (
        .clk        (clk),
        .rstn       (rstn),
        .clear      (load_start),
        .byte_valid (accept && (state_q == StLoad)),
        .byte_data  (bus.rx_data),
        .lane_last  (pk_lane_last),
        .word_valid (pk_word_valid),
        .word       (pk_word)
    );

    assign bus.imem_we    = pk_word_valid;
    assign bus.imem_addr  = addr_q;
    assign bus.imem_wdata = pk_word;

    assign busy        = stream_state;
    assign cpu_rst     = (state_q != StRun);
    assign halted      = (state_q == StHalt);
    assign err         = (state_q == StErr);
    assign cycle_count = count_q;

    always_comb begin
        state_d  = state_q;
        n_lo_d   = n_lo_q;
        n_d      = n_q;
        index_d  = index_q;
        end_pc_d = end_pc_q;
        addr_d   = addr_q;
        count_d  = count_q;
        unique case (state_q)
            StHdr0: begin
                if (accept) begin
                    n_lo_d  = bus.rx_data;
                    state_d = StHdr1;
                end
            end
            StHdr1: begin
                if (accept) begin
                    if (load_start) begin
                        n_d      = n_hdr;
                        index_d  = '0;
                        end_pc_d = ADDR_SIZE'({n_hdr - HDR_BITS'(1), 2'b00});
                        state_d  = StLoad;
                    end else begin
                        state_d = StErr;
                    end
                end
            end
            StLoad: begin
                // Address is latched with the final byte so it lines up with the write strobe.
                if (accept && pk_lane_last) begin
                    addr_d  = ADDR_SIZE'({index_q, 2'b00});
                    index_d = index_q + HDR_BITS'(1);
                end
                if (pk_word_valid && (index_q == n_q)) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                if (count_q != '1) begin
                    count_d = count_q + 32'd1;
                end
                if ((pcW == end_pc_q) && (count_q >= 32'(PIPE_DEPTH - 1))) begin
                    state_d = StHalt;
                end
            end
            StHalt, StErr: begin
                state_d = state_q;
            end
            default: begin
                state_d = StHdr0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rstn) begin
            state_q  <= StHdr0;
            n_lo_q   <= '0;
            n_q      <= '0;
            index_q  <= '0;
            end_pc_q <= '0;
            addr_q   <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            n_lo_q   <= n_lo_d;
            n_q      <= n_d;
            index_q  <= index_d;
            end_pc_q <= end_pc_d;
            addr_q   <= addr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed, table-driven bench for the instruction-memory boot loader.
module tb_imem_boot_loader;

    logic        clk = 1'b0;
    logic        rstn;
    logic [31:0] pcW;
    logic        cpu_rst;
    logic        busy;
    logic        halted;
    logic        err;
    logic [31:0] cycle_count;

    always #5 clk = ~clk;

    imem_boot_loader_if #(.ADDR_SIZE(32)) bus ();

    imem_boot_loader #(
        .ADDR_SIZE   (32),
        .DEPTH_WORDS (1024),
        .PIPE_DEPTH  (5)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .bus         (bus),
        .pcW         (pcW),
        .cpu_rst     (cpu_rst),
        .busy        (busy),
        .halted      (halted),
        .err         (err),
        .cycle_count (cycle_count)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        int          cyc;
        logic        rst;
    } wr_t;

    typedef struct {
        logic [7:0]  b0;
        logic [7:0]  b1;
        logic [7:0]  b2;
        logic [7:0]  b3;
        logic [31:0] exp_addr;
        logic [31:0] exp_data;
    } load_vec_t;

    typedef struct {
        logic [7:0] lo;
        logic [7:0] hi;
        logic       exp_err;
    } hdr_vec_t;

    wr_t  wq[$];
    int   fq[$];
    int   tb_cyc = 0;
    logic prev_rst = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;

    load_vec_t vt[3];
    load_vec_t vr[2];
    hdr_vec_t  hv[4];

    always @(posedge clk) tb_cyc <= tb_cyc + 1;

    always @(negedge clk) begin
        if (bus.imem_we === 1'b1) wq.push_back('{bus.imem_addr, bus.imem_wdata, tb_cyc, cpu_rst});
        if (cpu_rst === 1'b0 && prev_rst === 1'b1) fq.push_back(tb_cyc);
        prev_rst <= cpu_rst;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rstn = 1'b1;
        bus.rx_valid = 1'b0;
        @(negedge clk);
        rstn = 1'b0;
    endtask

    task automatic send(input logic [7:0] b, input bit gap);
        @(negedge clk);
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        if (gap) begin
            @(negedge clk);
            bus.rx_valid = 1'b0;
        end
    endtask

    task automatic idle();
        @(negedge clk);
        bus.rx_valid = 1'b0;
    endtask

    // Leaves the caller at the first negedge where cpu_rst is low.
    task automatic wait_run(input string name);
        int t;
        t = 0;
        while (cpu_rst !== 1'b0 && t < 400) begin
            @(negedge clk);
            t++;
        end
        if (cpu_rst !== 1'b0) begin
            n_vec++;
            n_err++;
            $display("FAIL %s: cpu_rst never released, got %b, expected 0", name, cpu_rst);
        end
    endtask

    task automatic check_loaded(input string name, input int mark, input int fmark, input bit gap);
        int nw;
        for (int i = 0; i < 3; i++) begin
            send(vt[i].b0, gap);
            send(vt[i].b1, gap);
            send(vt[i].b2, gap);
            send(vt[i].b3, gap);
        end
        idle();
        wait_run(name);
        repeat (3) @(negedge clk);
        nw = wq.size() - mark;
        chk({name, "_nwrites"}, 32'(nw), 32'd3);
        if (nw == 3) begin
            for (int i = 0; i < 3; i++) begin
                chk({name, "_addr"}, wq[mark+i].addr, vt[i].exp_addr);
                chk({name, "_data"}, wq[mark+i].data, vt[i].exp_data);
                chk({name, "_rst_during_load"}, 32'(wq[mark+i].rst), 32'd1);
            end
            chk({name, "_nfalls"}, 32'(fq.size() - fmark), 32'd1);
            if (fq.size() > fmark) begin
                chk({name, "_rst_fall_cycle"}, 32'(fq[fmark]), 32'(wq[mark+2].cyc + 1));
            end
        end
    endtask

    initial begin
        int mark;
        int fmark;
        int nw;

        vt[0] = '{8'h10, 8'h11, 8'h12, 8'h13, 32'h0, 32'h1312_1110};
        vt[1] = '{8'h14, 8'h15, 8'h16, 8'h17, 32'h4, 32'h1716_1514};
        vt[2] = '{8'h18, 8'h19, 8'h1A, 8'h1B, 32'h8, 32'h1B1A_1918};
        vr[0] = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 32'h0, 32'hA3A2_A1A0};
        vr[1] = '{8'hA4, 8'hA5, 8'hA6, 8'hA7, 32'h4, 32'hA7A6_A5A4};
        hv[0] = '{8'h00, 8'h00, 1'b1};
        hv[1] = '{8'h01, 8'h04, 1'b1};
        hv[2] = '{8'h00, 8'h04, 1'b0};
        hv[3] = '{8'h01, 8'h00, 1'b0};

        rstn         = 1'b1;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        pcW          = 32'hFFFF_FFF0;

        // Reset values
        repeat (2) @(negedge clk);
        chk("rst_rx_ready", 32'(bus.rx_ready), 32'd0);
        chk("rst_imem_we", 32'(bus.imem_we), 32'd0);
        chk("rst_imem_addr", bus.imem_addr, 32'd0);
        chk("rst_imem_wdata", bus.imem_wdata, 32'd0);
        chk("rst_cpu_rst", 32'(cpu_rst), 32'd1);
        chk("rst_busy", 32'(busy), 32'd1);
        chk("rst_halted", 32'(halted), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_cycle_count", cycle_count, 32'd0);
        rstn = 1'b0;

        // Three words streamed back-to-back
        mark  = wq.size();
        fmark = fq.size();
        send(8'h03, 1'b0);
        send(8'h00, 1'b0);
        check_loaded("b2b", mark, fmark, 1'b0);

        // Same image with a gap after every byte
        do_reset();
        mark  = wq.size();
        fmark = fq.size();
        send(8'h03, 1'b1);
        send(8'h00, 1'b1);
        check_loaded("gap", mark, fmark, 1'b1);

        // Header legality
        for (int v = 0; v < 4; v++) begin
            do_reset();
            mark = wq.size();
            send(hv[v].lo, 1'b0);
            send(hv[v].hi, 1'b0);
            idle();
            chk("hdr_err", 32'(err), 32'(hv[v].exp_err));
            chk("hdr_rx_ready", 32'(bus.rx_ready), 32'(!hv[v].exp_err));
            chk("hdr_busy", 32'(busy), 32'(!hv[v].exp_err));
            chk("hdr_cpu_rst", 32'(cpu_rst), 32'd1);
            if (hv[v].exp_err) begin
                for (int i = 0; i < 4; i++) send(8'hEE, 1'b0);
                idle();
                repeat (2) @(negedge clk);
                chk("hdr_err_no_write", 32'(wq.size() - mark), 32'd0);
                chk("hdr_err_hold", 32'(err), 32'd1);
            end
        end

        // 31 words, then walk pcW up to end_pc = 0x78
        do_reset();
        mark = wq.size();
        send(8'h1F, 1'b0);
        send(8'h00, 1'b0);
        for (int i = 0; i < 124; i++) send(8'(i) ^ 8'h5A, 1'b0);
        idle();
        wait_run("pcwalk");
        nw = wq.size() - mark;
        chk("pcwalk_nwrites", 32'(nw), 32'd31);
        if (nw == 31) begin
            chk("pcwalk_last_addr", wq[mark+30].addr, 32'h78);
            chk("pcwalk_last_data", wq[mark+30].data, 32'h2120_2322);
        end
        chk("pcwalk_count_start", cycle_count, 32'd0);
        for (int k = 0; k < 31; k++) begin
            pcW = 32'(4 * k);
            if (k == 30) chk("pcwalk_no_early_halt", 32'(halted), 32'd0);
            @(negedge clk);
        end
        chk("pcwalk_halted", 32'(halted), 32'd1);
        chk("pcwalk_cpu_rst", 32'(cpu_rst), 32'd1);
        chk("pcwalk_count", cycle_count, 32'd31);
        repeat (3) @(negedge clk);
        chk("pcwalk_count_frozen", cycle_count, 32'd31);
        chk("pcwalk_halt_hold", 32'(halted), 32'd1);

        // Single word with pcW already at end_pc: pipeline-fill mask
        pcW = 32'h0;
        do_reset();
        send(8'h01, 1'b0);
        send(8'h00, 1'b0);
        send(8'hDE, 1'b0);
        send(8'hAD, 1'b0);
        send(8'hBE, 1'b0);
        send(8'hEF, 1'b0);
        idle();
        wait_run("mask");
        chk("mask_start_halted", 32'(halted), 32'd0);
        repeat (4) @(negedge clk);
        chk("mask_count4", cycle_count, 32'd4);
        chk("mask_halted_at4", 32'(halted), 32'd0);
        @(negedge clk);
        chk("mask_halted", 32'(halted), 32'd1);
        chk("mask_count", cycle_count, 32'd5);

        // Reset mid-load after 6 payload bytes, then reload two words
        pcW = 32'hFFFF_FFF0;
        do_reset();
        send(8'h03, 1'b0);
        send(8'h00, 1'b0);
        for (int i = 0; i < 6; i++) send(8'h55 + 8'(i), 1'b0);
        do_reset();
        mark = wq.size();
        send(8'h02, 1'b0);
        send(8'h00, 1'b0);
        for (int i = 0; i < 2; i++) begin
            send(vr[i].b0, 1'b0);
            send(vr[i].b1, 1'b0);
            send(vr[i].b2, 1'b0);
            send(vr[i].b3, 1'b0);
        end
        idle();
        wait_run("reload");
        repeat (2) @(negedge clk);
        nw = wq.size() - mark;
        chk("reload_nwrites", 32'(nw), 32'd2);
        if (nw == 2) begin
            for (int i = 0; i < 2; i++) begin
                chk("reload_addr", wq[mark+i].addr, vr[i].exp_addr);
                chk("reload_data", wq[mark+i].data, vr[i].exp_data);
            end
        end
        chk("reload_err", 32'(err), 32'd0);
        chk("reload_halted", 32'(halted), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
